// File: rtl/conv_band_seq_pkg.sv
// conv_band_seq_pkg: shared widths, address defaults and state encoding for the band sequencer
package conv_band_seq_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 9;
  localparam int CH = 3;
  localparam int K = 2;
  localparam int RPP = 4;
  localparam int OUT_WIDTH = 16;
  localparam int MAX_W = 15;
  localparam int BAND = RPP + K - 1;
  localparam int COL_W = CH * BAND * DATA_WIDTH;
  localparam int WIN_W = K * COL_W;
  localparam int FILT_W = CH * K * K * DATA_WIDTH;
  localparam int RES_W = RPP * OUT_WIDTH;
  localparam int WW = $clog2(MAX_W + 1);
  localparam logic [ADDR_WIDTH-1:0] FILTER_BASE = 9'd240;
  localparam logic [ADDR_WIDTH-1:0] OUT_BASE = 9'd384;
  typedef enum logic [2:0] {IDLE, LD_FILT, FILL, RUN, DRAIN} state_t;
endpackage

// File: rtl/conv_band_seq_if.sv
// conv_band_seq_if: control, SRAM and conv-core signals of the band sequencer
interface conv_band_seq_if;
  import conv_band_seq_pkg::*;
  logic start, abort, cfg_pad;
  logic [WW-1:0] cfg_img_w;
  logic [7:0] cfg_bands;
  logic busy, done, err;
  logic rd_en, wr_en;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic [COL_W-1:0] rd_data;
  logic [RES_W-1:0] wr_data, core_out;
  logic [FILT_W-1:0] filt;
  logic [WIN_W-1:0] win;
  logic win_valid, core_valid;
  modport master (
    input start, abort, cfg_img_w, cfg_bands, cfg_pad, rd_data, core_valid, core_out,
    output busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data, filt, win, win_valid
  );
  modport slave (
    output start, abort, cfg_img_w, cfg_bands, cfg_pad, rd_data, core_valid, core_out,
    input busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data, filt, win, win_valid
  );
endinterface

// File: rtl/conv_band_seq_win_shift.sv
// conv_win_shift: K-column sliding window, new column enters MSBs; valid strobes once K columns of a band are in
module conv_win_shift
  import conv_band_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift,
  input  logic             zero,
  input  logic             first,
  input  logic [COL_W-1:0] col,
  output logic [WIN_W-1:0] win,
  output logic             win_valid
);
  localparam int NW = $clog2(K + 1);
  logic [NW-1:0] cnt, cnt_n;
  always_comb cnt_n = first ? NW'(1) : (cnt == NW'(K) ? cnt : cnt + 1'b1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
      cnt <= '0;
      win_valid <= 1'b0;
    end else if (clr) begin
      win <= '0;
      cnt <= '0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= shift && cnt_n >= NW'(K);
      if (shift) begin
        win <= {(zero ? {COL_W{1'b0}} : col), win[WIN_W-1:COL_W]};
        cnt <= cnt_n;
      end
    end
  end
endmodule

// File: rtl/conv_band_seq.sv
// conv_band_seq: loads the filter, streams column-words band by band through the window
// and writes every conv-core result to consecutive output addresses.
module conv_band_seq
  import conv_band_seq_pkg::*;
(
  input logic clk,
  input logic rst_n,
  conv_band_seq_if.master bus
);
  localparam int CW = WW + 1;
  localparam int TW = CW + 8;
  state_t state;
  logic [WW-1:0] img_w;
  logic [7:0] bands, band;
  logic [CW-1:0] col, ncols;
  logic [TW-1:0] total, wcnt;
  logic [ADDR_WIDTH+7:0] base;
  logic bad, last_col, rd_v;
  logic s_col, s_pad, s_first, d_col, d_pad, d_first;
  always_comb begin
    bad = bus.cfg_img_w < WW'(K) || bus.cfg_bands == 8'd0;
    base = (ADDR_WIDTH+8)'(band) * (ADDR_WIDTH+8)'(img_w);
    last_col = col == ncols - 1'b1;
  end
  // issue flags (s_*) travel with rd_en; d_* line up with the returned rd_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {img_w, bands, band, col, ncols, total, wcnt} <= '0;
      {rd_v, s_col, s_pad, s_first, d_col, d_pad, d_first} <= '0;
      {bus.busy, bus.done, bus.err, bus.rd_en, bus.wr_en} <= '0;
      bus.rd_addr <= '0;
      bus.wr_addr <= OUT_BASE;
      bus.wr_data <= '0;
      bus.filt <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      rd_v <= bus.rd_en;
      {d_col, d_pad, d_first} <= {s_col, s_pad, s_first};
      bus.wr_en <= bus.core_valid && bus.busy && !bus.abort;
      bus.wr_data <= bus.core_valid ? bus.core_out : bus.wr_data;
      if (bus.wr_en) bus.wr_addr <= bus.wr_addr + 1'b1;
      if (bus.wr_en && bus.busy) wcnt <= wcnt + 1'b1;
      if (bus.abort) begin
        state <= IDLE;
        bus.busy <= 1'b0;
        bus.rd_en <= 1'b0;
        {rd_v, s_col, s_pad, s_first, d_col, d_pad, d_first} <= '0;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            if (bad) bus.err <= 1'b1;
            else begin
              img_w <= bus.cfg_img_w;
              bands <= bus.cfg_bands;
              ncols <= CW'(bus.cfg_img_w) + (bus.cfg_pad ? CW'(K - 1) : '0);
              total <= TW'(bus.cfg_pad ? bus.cfg_img_w : bus.cfg_img_w - WW'(K - 1)) * TW'(bus.cfg_bands);
              {band, col, wcnt} <= '0;
              bus.busy <= 1'b1;
              bus.rd_en <= 1'b1;
              bus.rd_addr <= FILTER_BASE;
              bus.wr_addr <= OUT_BASE;
              state <= LD_FILT;
            end
          end
          LD_FILT: begin
            bus.rd_en <= 1'b0;
            if (rd_v) begin
              bus.filt <= bus.rd_data[FILT_W-1:0];
              state <= FILL;
            end
          end
          FILL, RUN: begin
            bus.rd_en <= col < CW'(img_w);
            bus.rd_addr <= ADDR_WIDTH'(base + (ADDR_WIDTH+8)'(col));
            s_col <= 1'b1;
            s_pad <= col >= CW'(img_w);
            s_first <= col == '0;
            col <= last_col ? '0 : col + 1'b1;
            if (!last_col) state <= (col + 1'b1 >= CW'(K - 1)) ? RUN : FILL;
            else if (band == bands - 1'b1) state <= DRAIN;
            else begin
              band <= band + 1'b1;
              state <= FILL;
            end
          end
          DRAIN: begin
            bus.rd_en <= 1'b0;
            {s_col, s_pad, s_first} <= '0;
            if (bus.wr_en && wcnt == total - 1'b1) begin
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  conv_win_shift u_win (
    .clk(clk), .rst_n(rst_n), .clr(bus.abort), .shift(d_col), .zero(d_pad), .first(d_first),
    .col(bus.rd_data), .win(bus.win), .win_valid(bus.win_valid)
  );
endmodule

// File: tb/tb_conv_band_seq.sv
// tb_conv_band_seq: SRAM + 1-cycle conv core models around conv_band_seq; expected writes
// are queued when a job starts and popped on every wr_en.
module tb_conv_band_seq;
  import conv_band_seq_pkg::*;
  typedef struct {logic [ADDR_WIDTH-1:0] addr; logic [RES_W-1:0] data;} exp_t;
  logic clk;
  logic rst_n = 1'b0;
  conv_band_seq_if bus();
  conv_band_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [COL_W-1:0] mem [512];
  exp_t sb[$];
  logic [ADDR_WIDTH-1:0] rd_log[$];
  int checks = 0, passes = 0, cyc = 0, wv_cnt = 0, wr_cnt = 0, done_cnt = 0, last_wr_cyc = 0;
  int rd0, wv0, wr0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic logic [RES_W-1:0] conv(input logic [WIN_W-1:0] w, input logic [FILT_W-1:0] f);
    logic [RES_W-1:0] r;
    int acc;
    r = '0;
    for (int row = 0; row < RPP; row++) begin
      acc = 0;
      for (int ch = 0; ch < CH; ch++)
        for (int kr = 0; kr < K; kr++)
          for (int kc = 0; kc < K; kc++)
            acc += int'(w[kc*COL_W + ((row+kr)*CH+ch)*DATA_WIDTH +: DATA_WIDTH]) *
                   int'(f[((ch*K+kr)*K+kc)*DATA_WIDTH +: DATA_WIDTH]);
      r[row*OUT_WIDTH +: OUT_WIDTH] = acc[OUT_WIDTH-1:0];
    end
    return r;
  endfunction
  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  always @(posedge clk) cyc++;
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  always @(posedge clk) begin
    bus.core_valid <= rst_n && bus.win_valid;
    bus.core_out <= conv(bus.win, bus.filt);
  end
  always @(negedge clk) if (rst_n) begin
    exp_t e;
    if (bus.rd_en) rd_log.push_back(bus.rd_addr);
    if (bus.win_valid) wv_cnt++;
    if (bus.done) done_cnt++;
    if (bus.wr_en) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      chk("wr_pending", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", bus.wr_addr, e.addr);
        chk("wr_data", bus.wr_data, e.data);
      end
    end
  end
  task automatic launch(int w, int nb, bit pd);
    int per, n;
    logic [WIN_W-1:0] wv;
    per = pd ? w : w - K + 1;
    n = 0;
    for (int b = 0; b < nb; b++)
      for (int j = 0; j < per; j++) begin
        for (int kc = 0; kc < K; kc++)
          wv[kc*COL_W +: COL_W] = (j + kc < w) ? mem[(b*w + j + kc) % 512] : '0;
        sb.push_back('{addr: ADDR_WIDTH'(384 + n), data: conv(wv, mem[240][FILT_W-1:0])});
        n++;
      end
    rd0 = rd_log.size();
    wv0 = wv_cnt;
    wr0 = wr_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.cfg_img_w = WW'(w);
    bus.cfg_bands = 8'(nb);
    bus.cfg_pad = pd;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic run_job(int w, int nb, bit pd);
    int per, to;
    per = pd ? w : w - K + 1;
    launch(w, nb, pd);
    to = 0;
    while (!bus.done && to < 3000) begin
      @(negedge clk);
      to++;
    end
    chk("done_seen", bus.done, 1);
    chk("done_after_last_wr", cyc - last_wr_cyc, 1);
    chk("busy_falls_with_done", bus.busy, 0);
    chk("wr_count", wr_cnt - wr0, per * nb);
    chk("sb_empty", sb.size(), 0);
    chk("wr_addr_end", bus.wr_addr, 384 + per * nb);
    chk("rd_count", rd_log.size() - rd0, 1 + w * nb);
    chk("rd_filter_addr", rd_log[rd0], 240);
    chk("rd_last_band_addr", rd_log[rd0 + 1 + w * (nb - 1)], w * (nb - 1));
    chk("win_valid_cycles", wv_cnt - wv0, per * nb);
  endtask
  task automatic bad_start(int w, int nb);
    rd0 = rd_log.size();
    @(negedge clk);
    bus.start = 1'b1;
    bus.cfg_img_w = WW'(w);
    bus.cfg_bands = 8'(nb);
    @(negedge clk);
    bus.start = 1'b0;
    chk("err_pulse", bus.err, 1);
    chk("err_busy", bus.busy, 0);
    @(negedge clk);
    chk("err_one_cycle", bus.err, 0);
    repeat (3) @(negedge clk);
    chk("err_no_rd", rd_log.size() - rd0, 0);
  endtask
  initial begin
    int d0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_img_w = '0;
    bus.cfg_bands = '0;
    bus.cfg_pad = 1'b0;
    for (int a = 0; a < 512; a++)
      for (int i = 0; i < COL_W / 8; i++) mem[a][i*8 +: 8] = 8'(a * 3 + i * 5 + 1);
    for (int i = 0; i < COL_W / 8; i++) mem[240][i*8 +: 8] = (i < FILT_W / 8) ? 8'(i + 1) : 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 384);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_win_valid", bus.win_valid, 0);
    chk("rst_filt", bus.filt, 0);
    chk("rst_win", bus.win, 0);
    rst_n = 1'b1;
    run_job(8, 1, 0);
    run_job(8, 1, 1);
    run_job(4, 2, 0);
    bad_start(1, 1);
    bad_start(8, 0);
    launch(8, 1, 0);
    repeat (5) @(negedge clk);
    bus.abort = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_win_valid", bus.win_valid, 0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    sb.delete();
    run_job(5, 1, 0);
    fork
      run_job(8, 1, 0);
      begin
        repeat (6) @(negedge clk);
        bus.start = 1'b1;
        bus.cfg_img_w = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join
    launch(8, 1, 1);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_rd_en", bus.rd_en, 0);
    chk("arst_wr_en", bus.wr_en, 0);
    chk("arst_win_valid", bus.win_valid, 0);
    chk("arst_filt", bus.filt, 0);
    chk("arst_win", bus.win, 0);
    chk("arst_wr_addr", bus.wr_addr, 384);
    @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
    run_job(3, 2, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
